// File: rtl/prioq_pkg.sv
// Shared types and helpers for the priority-queue controller.
// The priority of an entry is its top PW bits.
package prioq_pkg;

  localparam int DW = 4;
  localparam int PW = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SCAN = ST_SCAN,
    EMIT = ST_EMIT
  } state_e;

  typedef logic [DW-1:0] entry_t;

  function automatic logic [PW-1:0] prio(input entry_t e);
    return PW'(e >> (DW - PW));
  endfunction

endpackage

// File: rtl/prioq_rr_arb.sv
// Two-requester round-robin arbiter. The pointer names the producer that
// wins the next two-way contest, and it flips after every contested grant.
module prioq_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en && (req == 2'b11)) ptr_d = ~ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/prioq_ctrl.sv
// Priority-queue controller: round-robin enqueue from two producers and a
// scan/emit dequeue FSM. Define PRIOQ_ERR_EN to add sticky err_ovf/err_udf.
module prioq_ctrl
  import prioq_pkg::*;
#(
  parameter int DEPTH = 6,
  parameter int DW    = prioq_pkg::DW,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq0_valid,
  input  logic [DW-1:0] enq0_data,
  output logic          enq0_ready,
  input  logic          enq1_valid,
  input  logic [DW-1:0] enq1_data,
  output logic          enq1_ready,
  input  logic          deq_req,
  output logic          deq_valid,
  output logic [DW-1:0] deq_data,
  output logic [CW-1:0] count,
  output logic          isfull,
  output logic          isempty,
  output state_e        dbg_state
`ifdef PRIOQ_ERR_EN
  ,
  output logic          err_ovf,
  output logic          err_udf
`endif
);

  // Handshake: an entry moves when enqX_valid and enqX_ready are both high in
  // the same cycle; ready is combinational and never depends on data. deq_req
  // is a level held by the consumer; deq_valid is a single-cycle pulse.

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] best_q, best_d;
  logic [CW-1:0] scan_q, scan_d;
  logic [DW-1:0] arr_q [DEPTH];
  logic [DW-1:0] arr_d [DEPTH];
  logic          deq_valid_q, deq_valid_d;
  logic [DW-1:0] deq_data_q, deq_data_d;

  logic          deq_accept;
  logic          arb_en;
  logic [1:0]    arb_req, arb_gnt;
  logic [DW-1:0] wr_ent, scan_ent, best_ent;

  assign isfull     = (count_q == CW'(DEPTH));
  assign isempty    = (count_q == '0);
  assign deq_accept = (state_q == ST_IDLE) && deq_req && !isempty;
  assign arb_en     = (state_q == ST_IDLE) && !deq_accept && !isfull;
  assign arb_req    = {enq1_valid, enq0_valid};

  prioq_rr_arb u_arb (
    .clk (clk),
    .rst (rst),
    .req (arb_req),
    .en  (arb_en),
    .gnt (arb_gnt)
  );

  assign enq0_ready = arb_gnt[0];
  assign enq1_ready = arb_gnt[1];
  assign wr_ent     = arb_gnt[1] ? enq1_data : enq0_data;

  // Index decode by comparison keeps the narrow count-width indices in range.
  always_comb begin
    scan_ent = '0;
    best_ent = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) == scan_q) scan_ent = arr_q[i];
      if (CW'(i) == best_q) best_ent = arr_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    best_d      = best_q;
    scan_d      = scan_q;
    deq_valid_d = 1'b0;
    deq_data_d  = deq_data_q;
    arr_d       = arr_q;
    case (state_q)
      ST_IDLE: begin
        if (deq_accept) begin
          best_d  = '0;
          scan_d  = CW'(1);
          state_d = ST_SCAN;
        end else if (|arb_gnt) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == count_q) arr_d[i] = wr_ent;
          end
          count_d = count_q + 1'b1;
        end
      end
      ST_SCAN: begin
        // Strict compare keeps the oldest entry among equal priorities.
        if (scan_q < count_q) begin
          if (prio(scan_ent) > prio(best_ent)) best_d = scan_q;
          scan_d = scan_q + 1'b1;
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        deq_data_d  = best_ent;
        deq_valid_d = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
          if ((CW'(i) >= best_q) && (CW'(i + 1) < count_q)) arr_d[i] = arr_q[i + 1];
        end
        count_d = count_q - 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      best_q      <= '0;
      scan_q      <= '0;
      deq_valid_q <= 1'b0;
      deq_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      best_q      <= best_d;
      scan_q      <= scan_d;
      deq_valid_q <= deq_valid_d;
      deq_data_q  <= deq_data_d;
    end
  end

  // Storage is qualified by count_q, so it needs no reset.
  always_ff @(posedge clk) begin
    arr_q <= arr_d;
  end

  assign deq_valid = deq_valid_q;
  assign deq_data  = deq_data_q;
  assign count     = count_q;
  assign dbg_state = state_e'(state_q);

`ifdef PRIOQ_ERR_EN
  logic err_ovf_q, err_ovf_d;
  logic err_udf_q, err_udf_d;

  always_comb begin
    err_ovf_d = err_ovf_q | ((state_q == ST_IDLE) && isfull && (enq0_valid || enq1_valid));
    err_udf_d = err_udf_q | ((state_q == ST_IDLE) && isempty && deq_req);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`endif

endmodule
